send_row: RTL and testbench
===========================

# send_row

Row streamer that feeds the DCNN datapath one image row at a time. It accepts a 480-bit packed row from the CPU-side loader when `ready` is high and serializes it as 32 pixels of 15 bits, one pixel per clock. It then pulses `send` to request the next row from the loader. After the final row of the image it raises `stop`, which halts further row fetches.

## Interface
Parameters:
- PIX_W, 15, bits per pixel
- PIX_PER_ROW, 32, pixels per row; row width = PIX_W*PIX_PER_ROW = 480
- NUM_ROWS, 32, rows per image

Ports (declaration order: row, clk, ready, send, stop, rst, dout, dout_valid):
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- row  input  480  packed row; pixel k = row[k*15 +: 15]
- ready  input  1  level qualifier: `row` holds valid data
- send  output  1  one-cycle request for the next row
- stop  output  1  all NUM_ROWS rows streamed; sticky until rst
- dout  output  15  current pixel
- dout_valid  output  1  `dout` valid this cycle

## Operation
- States: IDLE, SHIFT, REQ, WAIT, DONE.
- IDLE:
  - If ready=1: capture `row` into the shift register, clear pix_cnt, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Drive dout = shreg[14:0] with dout_valid=1, shift shreg right by 15, increment pix_cnt.
  - When pix_cnt reaches PIX_PER_ROW-1:
    - If row_cnt = NUM_ROWS-1, go to DONE.
    - Otherwise increment row_cnt and go to REQ.
- REQ: send=1 for exactly this cycle, then go to WAIT.
- WAIT: one idle cycle so the loader can update `row`, then go to IDLE.
- DONE: stop=1, send=0, dout_valid=0. Stays in DONE until rst.
- `ready` and `row` are ignored outside IDLE. A row change during SHIFT does not corrupt the output.
- ready may remain high continuously. The WAIT state guarantees the next capture sees the new row.
- dout holds 0 whenever dout_valid=0.
- Counters: pix_cnt is 5 bits, row_cnt is clog2(NUM_ROWS) bits. Neither counter wraps; DONE is terminal.

## Timing
- Reset values: send=0, stop=0, dout=0, dout_valid=0, state=IDLE, row_cnt=0, pix_cnt=0.
- rst wins over every other condition. Asserting rst mid-SHIFT, REQ or DONE aborts and returns to reset state on the next edge.
- Per row, with the capture edge as cycle 0:
  - dout_valid=1 in cycles 1..32, pixel k appears in cycle k+1.
  - send=1 in cycle 33.
  - WAIT in cycle 34.
  - Earliest next capture is cycle 35. The row period is 35 cycles with ready held high.
- Last row: stop rises in cycle 33 instead of send. No send pulse is issued for the last row.
- Outputs are registered and change only on clk rising edges.

## Structure
- Shared package `dcnn_pkg`:
  - PIX_W, PIX_PER_ROW and NUM_ROWS defaults.
  - ROW_W = PIX_W*PIX_PER_ROW.
  - State enum typedef `send_row_state_t`.
- Sub-module `row_serializer`: 480-bit parallel-load shift register plus pixel counter. Outputs dout and a last_pix flag.
- The FSM, row counter, send and stop live in the top module.

## Test plan
- Reset: hold rst 3 cycles with ready=1 and arbitrary row → send=0, stop=0, dout_valid=0, dout=0 throughout. The first capture occurs on the first edge after rst drops.
- Single row, pixel k = k: dout_valid high for exactly 32 cycles, dout sequence 0,1,…,31. send is high only in cycle 33.
- Ready gating: ready=0 for 10 cycles in IDLE → no dout_valid and no send. Raising ready triggers capture on the next edge.
- Row change mid-SHIFT: alter `row` during cycle 10 → output still matches the originally captured row.
- Full image, NUM_ROWS=4 and row r with every pixel = r:
  - Exactly 3 send pulses, 35 cycles apart.
  - 128 valid pixels in order 0…0,1…1,2…2,3…3.
  - stop rises in cycle 33 of row 3 and stays high for 50 further cycles, with no send or dout_valid.
- Reset mid-operation: assert rst in SHIFT of row 2 → all outputs return to 0. The next image restarts at row_cnt=0, and the full 32-pixel row plus send sequence repeats.

Source files
------------

// File: rtl/dcnn_pkg.sv
// Shared DCNN definitions: default geometry of one image and the row
// streamer's state encoding.
package dcnn_pkg;

  localparam int unsigned DEF_PIX_W       = 15;
  localparam int unsigned DEF_PIX_PER_ROW = 32;
  localparam int unsigned DEF_NUM_ROWS    = 32;
  localparam int unsigned DEF_ROW_W       = DEF_PIX_W * DEF_PIX_PER_ROW;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    REQ,
    WAIT,
    DONE
  } send_row_state_t;

endpackage

// File: rtl/row_serializer.sv
// Parallel-load row shift register with pixel counter; emits one registered
// pixel per shift cycle (LSB pixel first) and flags the last pixel of the row.
module row_serializer
  import dcnn_pkg::*;
#(
  parameter int unsigned PIX_W       = DEF_PIX_W,
  parameter int unsigned PIX_PER_ROW = DEF_PIX_PER_ROW,
  localparam int unsigned ROW_W      = PIX_W * PIX_PER_ROW,
  localparam int unsigned CNT_W      = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [PIX_W-1:0] dout_o,
  output logic             last_pix_o
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_ROW - 1);

  logic [ROW_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] dout_q, dout_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = '0;
    if (load_i) begin
      shreg_d = row_i;
      cnt_d   = '0;
    end else if (shift_i) begin
      dout_d  = shreg_q[PIX_W-1:0];
      shreg_d = shreg_q >> PIX_W;
      if (cnt_q != LAST_PIX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o     = dout_q;
  assign last_pix_o = (cnt_q == LAST_PIX);

endmodule

// File: rtl/send_row.sv
// Row streamer: captures a packed row when ready, serializes it one pixel
// per clock, then requests the next row; raises a sticky stop after the last.
module send_row
  import dcnn_pkg::*;
#(
  parameter int unsigned PIX_W       = DEF_PIX_W,
  parameter int unsigned PIX_PER_ROW = DEF_PIX_PER_ROW,
  parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
  localparam int unsigned ROW_W      = PIX_W * PIX_PER_ROW,
  localparam int unsigned RC_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic [ROW_W-1:0] row,
  input  logic             clk,
  input  logic             ready,
  output logic             send,
  output logic             stop,
  input  logic             rst,
  output logic [PIX_W-1:0] dout,
  output logic             dout_valid
);

  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(NUM_ROWS - 1);

  send_row_state_t state_q, state_d;
  logic [RC_W-1:0] row_cnt_q, row_cnt_d;
  logic            send_q, send_d;
  logic            stop_q, stop_d;
  logic            valid_q, valid_d;
  logic            load, shift, last_pix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      send_q    <= 1'b0;
      stop_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      send_q    <= send_d;
      stop_q    <= stop_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      IDLE:  if (ready) state_d = SHIFT;
      SHIFT: if (last_pix) begin
        if (row_cnt_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          state_d   = REQ;
          row_cnt_d = row_cnt_q + RC_W'(1);
        end
      end
      REQ:     state_d = WAIT;
      WAIT:    state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the current state and registered, so every output trails
  // its state by one clock (pixel k lands one cycle after its SHIFT cycle).
  always_comb begin
    load    = (state_q == IDLE) && ready;
    shift   = (state_q == SHIFT);
    send_d  = (state_q == REQ);
    stop_d  = (state_q == DONE);
    valid_d = shift;
  end

  row_serializer #(
    .PIX_W       (PIX_W),
    .PIX_PER_ROW (PIX_PER_ROW)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .row_i      (row),
    .dout_o     (dout),
    .last_pix_o (last_pix)
  );

  assign send       = send_q;
  assign stop       = stop_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_send_row.sv
// Directed bench for send_row with a 4-row image.
module tb_send_row;

  localparam int unsigned PW  = 15;
  localparam int unsigned PPR = 32;
  localparam int unsigned NR  = 4;
  localparam int unsigned RW  = PW * PPR;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic [RW-1:0] row;
  logic          send, stop, dout_valid;
  logic [PW-1:0] dout;

  int checks = 0;
  int passes = 0;

  bit mon_en  = 1'b0;
  int n_send  = 0;
  int n_valid = 0;
  int cyc     = 0;
  int send_cyc[$];

  always #5 clk = ~clk;

  send_row #(
    .PIX_W       (PW),
    .PIX_PER_ROW (PPR),
    .NUM_ROWS    (NR)
  ) dut (
    .row        (row),
    .clk        (clk),
    .ready      (ready),
    .send       (send),
    .stop       (stop),
    .rst        (rst),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (send === 1'b1) begin
        n_send++;
        send_cyc.push_back(cyc);
      end
      if (dout_valid === 1'b1) n_valid++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_send"},  32'(send),       32'd0);
    chk({tag, "_stop"},  32'(stop),       32'd0);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_dout"},  32'(dout),       32'd0);
  endtask

  function automatic logic [RW-1:0] fill(input logic [PW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < int'(PPR); i++) r[i*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [RW-1:0] kpat();
    logic [RW-1:0] r;
    for (int i = 0; i < int'(PPR); i++) r[i*PW +: PW] = PW'(i);
    return r;
  endfunction

  // Presents r; the next posedge is the capture edge (cycle 0).
  task automatic run_row(input logic [RW-1:0] r, input bit last, input int change_at);
    logic [PW-1:0] px;
    row = r;
    step();
    chk("cap_valid", 32'(dout_valid), 32'd0);
    for (int k = 1; k <= int'(PPR); k++) begin
      step();
      px = r[(k-1)*PW +: PW];
      chk($sformatf("pix%0d_valid", k - 1), 32'(dout_valid), 32'd1);
      chk($sformatf("pix%0d_dout", k - 1),  32'(dout),       32'(px));
      chk($sformatf("pix%0d_send", k - 1),  32'(send),       32'd0);
      if (k == change_at) row = ~r;
    end
    step();
    chk("c33_send",  32'(send),       last ? 32'd0 : 32'd1);
    chk("c33_stop",  32'(stop),       last ? 32'd1 : 32'd0);
    chk("c33_valid", 32'(dout_valid), 32'd0);
    chk("c33_dout",  32'(dout),       32'd0);
    step();
    chk("c34_send",  32'(send),       32'd0);
    chk("c34_valid", 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b1;
    row   = fill(15'h2AAA);
    repeat (3) begin
      step();
      chk_zero("rst");
    end
    rst = 1'b0;

    // Row 0 with pixel k = k; row input scrambled in cycle 10 of SHIFT.
    run_row(kpat(), 1'b0, 10);
    run_row(fill(15'd1), 1'b0, 0);

    // Abort row 2 mid-SHIFT.
    row = fill(15'd2);
    step();
    repeat (5) step();
    chk("r2_valid", 32'(dout_valid), 32'd1);
    chk("r2_dout",  32'(dout),       32'd2);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst   = 1'b0;
    ready = 1'b0;

    repeat (10) begin
      step();
      chk("gate_valid", 32'(dout_valid), 32'd0);
      chk("gate_send",  32'(send),       32'd0);
    end

    // Full image after the abort; row_cnt must have restarted at 0.
    mon_en = 1'b1;
    ready  = 1'b1;
    for (int r = 0; r < int'(NR); r++)
      run_row(fill(PW'(r)), (r == int'(NR) - 1), 0);

    repeat (50) begin
      step();
      chk("done_stop",  32'(stop),       32'd1);
      chk("done_send",  32'(send),       32'd0);
      chk("done_valid", 32'(dout_valid), 32'd0);
      chk("done_dout",  32'(dout),       32'd0);
    end
    mon_en = 1'b0;

    chk("n_send",  32'(n_send),  32'd3);
    chk("n_valid", 32'(n_valid), 32'd128);
    for (int i = 1; i < send_cyc.size(); i++)
      chk("send_period", 32'(send_cyc[i] - send_cyc[i-1]), 32'd35);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
